// File: rtl/pipe_perf_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_counter_if
// Description : Control, event and read-back bundle for pipe_perf_counter.
//               The master drives control/event inputs; the slave (counter
//               block) returns the read port and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_perf_counter_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             clear_i;
  logic             hazard_stall_i;
  logic             is_branch_i;
  logic             next_nop_i;
  logic             retire_valid_i;
  logic             snapshot_i;
  logic [2:0]       rd_sel_i;
  logic [CNT_W-1:0] rd_data_o;
  logic             done_o;
  logic             overflow_o;

  modport master (
    output start_i, clear_i, hazard_stall_i, is_branch_i, next_nop_i,
           retire_valid_i, snapshot_i, rd_sel_i,
    input  rd_data_o, done_o, overflow_o
  );

  modport slave (
    input  start_i, clear_i, hazard_stall_i, is_branch_i, next_nop_i,
           retire_valid_i, snapshot_i, rd_sel_i,
    output rd_data_o, done_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_counter
// Description : Pipeline event monitor. Counts run cycles, load-use stalls,
//               flushes and retired instructions over a bounded window, with
//               snapshot shadows and a registered read port.
//               Optional macro PERF_SATURATE_EN: counters saturate instead of
//               wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_counter #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  pipe_perf_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Cycle count held just before the window-closing edge.
  localparam logic [CNT_W-1:0] c_LAST_CYCLE = CNT_W'(CYCLE_LIMIT - 1);
  localparam bit               c_LIMIT_EN   = (CYCLE_LIMIT != 0);

  // Counter index: 0 cycle, 1 stall, 2 flush, 3 retire.
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0][CNT_W-1:0]   r_cnt;
  logic [3:0][CNT_W-1:0]   r_shd;
  logic [3:0][CNT_W-1:0]   w_cnt_nxt;
  logic [3:0]              w_inc;
  logic [3:0]              w_wrap;
  logic                    w_run;
  logic                    w_last;
  logic [CNT_W-1:0]        w_rd_mux;
  logic [CNT_W-1:0]        r_rd_data;
  logic                    r_ovf;

  assign w_run  = (r_state == ST_RUN);
  // A branch in ID turns the hazard request into a control stall, not load-use.
  assign w_inc  = {w_run & bus.retire_valid_i,
                   w_run & bus.next_nop_i,
                   w_run & bus.hazard_stall_i & ~bus.is_branch_i,
                   w_run};
  assign w_last = c_LIMIT_EN && (r_cnt[0] == c_LAST_CYCLE);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_cnt
      // Increment arriving at all-ones: wrap or blocked, both flag overflow.
      assign w_wrap[k] = w_inc[k] & (&r_cnt[k]);
`ifdef PERF_SATURATE_EN
      assign w_cnt_nxt[k] = w_wrap[k] ? r_cnt[k] : r_cnt[k] + CNT_W'(w_inc[k]);
`else
      assign w_cnt_nxt[k] = r_cnt[k] + CNT_W'(w_inc[k]);
`endif
    end
  endgenerate

  // Next-state logic: clear dominates, DONE only exits through clear/reset.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start_i) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last)      w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Live counters, shadows and sticky overflow; shadows take post-update values.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      r_cnt <= '0;
      r_shd <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (bus.snapshot_i) r_shd <= w_cnt_nxt;
      r_ovf <= r_ovf | (|w_wrap);
    end
  end

  assign w_rd_mux = bus.rd_sel_i[2] ? r_shd[bus.rd_sel_i[1:0]]
                                    : r_cnt[bus.rd_sel_i[1:0]];

  // Registered read port: presents the counter value held before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rd_data <= '0;
    else       r_rd_data <= w_rd_mux;
  end

  assign bus.rd_data_o  = r_rd_data;
  assign bus.done_o     = (r_state == ST_DONE);
  assign bus.overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_perf_counter
// Description : Directed self-checking bench for pipe_perf_counter. Instance
//               A: CNT_W=32, CYCLE_LIMIT=64. Instance B: CNT_W=4, no limit,
//               exercises wrap/saturate (PERF_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_perf_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_perf_counter_if #(.CNT_W(32)) aif ();
  pipe_perf_counter_if #(.CNT_W(4))  bif ();

  pipe_perf_counter #(.CNT_W(32), .CYCLE_LIMIT(64)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (aif.slave)
  );

  pipe_perf_counter #(.CNT_W(4), .CYCLE_LIMIT(0)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Select a counter on A, let one edge register it, then compare.
  task automatic read_a(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    aif.rd_sel_i = sel;
    tick();
    check(tag, aif.rd_data_o, exp);
  endtask

  initial begin
    aif.start_i = 0; aif.clear_i = 0; aif.hazard_stall_i = 0; aif.is_branch_i = 0;
    aif.next_nop_i = 0; aif.retire_valid_i = 0; aif.snapshot_i = 0; aif.rd_sel_i = 3'd0;
    bif.start_i = 0; bif.clear_i = 0; bif.hazard_stall_i = 0; bif.is_branch_i = 0;
    bif.next_nop_i = 0; bif.retire_valid_i = 0; bif.snapshot_i = 0; bif.rd_sel_i = 3'd0;

    // Reset state
    tick(2);
    rst = 1'b0;
    check("rst_rd_data", aif.rd_data_o, 0);
    check("rst_done", {31'd0, aif.done_o}, 0);
    check("rst_ovf", {31'd0, aif.overflow_o}, 0);

    // Window with no events: 64 counting edges after the start edge
    aif.start_i = 1; tick(); aif.start_i = 0;
    tick(63);
    check("done_before_last", {31'd0, aif.done_o}, 0);
    tick();
    check("done_after_64", {31'd0, aif.done_o}, 1);
    aif.start_i = 1; tick(); aif.start_i = 0;   // ignored in DONE
    tick(9);
    check("done_held", {31'd0, aif.done_o}, 1);
    read_a(3'd0, 64, "idle_run_cycle");
    read_a(3'd1, 0,  "idle_run_stall");
    read_a(3'd2, 0,  "idle_run_flush");
    read_a(3'd3, 0,  "idle_run_retire");

    // Clear and start together: clear wins
    aif.clear_i = 1; aif.start_i = 1; tick(); aif.clear_i = 0; aif.start_i = 0;
    check("clear_done", {31'd0, aif.done_o}, 0);
    for (int s = 0; s < 8; s++) read_a(3'(s), 0, $sformatf("clear_sel%0d", s));

    // Event window with a snapshot on the 9->10 edge
    aif.start_i = 1; tick(); aif.start_i = 0;
    for (int i = 0; i < 64; i++) begin
      aif.hazard_stall_i = (i < 5);
      aif.is_branch_i    = (i < 2);
      aif.next_nop_i     = (i >= 10 && i < 13);
      aif.retire_valid_i = (i >= 20 && i < 40);
      aif.snapshot_i     = (i == 9);
      aif.start_i        = (i == 30);          // no effect while running
      tick();
    end
    aif.hazard_stall_i = 0; aif.is_branch_i = 0; aif.next_nop_i = 0;
    aif.retire_valid_i = 0; aif.snapshot_i = 0; aif.start_i = 0;
    check("ev_done", {31'd0, aif.done_o}, 1);
    read_a(3'd0, 64, "ev_live_cycle");
    read_a(3'd1, 3,  "ev_live_stall");
    read_a(3'd2, 3,  "ev_live_flush");
    read_a(3'd3, 20, "ev_live_retire");
    read_a(3'd4, 10, "ev_shd_cycle");
    read_a(3'd5, 3,  "ev_shd_stall");
    read_a(3'd6, 0,  "ev_shd_flush");
    read_a(3'd7, 0,  "ev_shd_retire");

    // Reset in the middle of a run
    aif.clear_i = 1; tick(); aif.clear_i = 0;
    aif.start_i = 1; tick(); aif.start_i = 0;
    aif.retire_valid_i = 1; tick(30);
    rst = 1'b1; aif.start_i = 1; tick();
    check("midrst_rd_data", aif.rd_data_o, 0);
    check("midrst_done", {31'd0, aif.done_o}, 0);
    tick();
    rst = 1'b0; aif.start_i = 0;
    tick(5);
    read_a(3'd0, 0, "midrst_idle_cycle");
    read_a(3'd3, 0, "midrst_idle_retire");
    aif.start_i = 1; tick(); aif.start_i = 0;
    tick(3);
    read_a(3'd0, 3, "midrst_fresh_cycle");
    aif.retire_valid_i = 0;

    // Narrow counter, no limit: 17 counting edges
    bif.start_i = 1; tick(); bif.start_i = 0;
    tick(15);
    check("b_ovf_at_15", {31'd0, bif.overflow_o}, 0);
    tick(2);
    check("b_ovf_after_17", {31'd0, bif.overflow_o}, 1);
    bif.rd_sel_i = 3'd0;
    tick();
`ifdef PERF_SATURATE_EN
    check("b_cycle_17", {28'd0, bif.rd_data_o}, 15);
`else
    check("b_cycle_17", {28'd0, bif.rd_data_o}, 1);
`endif
    check("b_done_never", {31'd0, bif.done_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
